// File: rtl/mc_control_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_fsm_if
// Description : Sequencer <-> datapath bundle: IR fields, flags and controls.
// Revision    : 1.0
// ============================================================================
interface mc_control_fsm_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       memReady;
  logic       pcWrite;
  logic       pcWriteCond;
  logic       isbeq;
  logic       iorD;
  logic       memRead;
  logic       memWrite;
  logic       irWrite;
  logic       regDst;
  logic [1:0] memtoReg;
  logic       regWrite;
  logic       aluSrcA;
  logic [1:0] aluSrcB;
  logic [3:0] aluOp;
  logic [1:0] pcSource;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero, memReady,
    output pcWrite, pcWriteCond, isbeq, iorD, memRead, memWrite, irWrite,
           regDst, memtoReg, regWrite, aluSrcA, aluSrcB, aluOp, pcSource,
           illegal, state
  );

  modport slave (
    output opcode, funct, zero, memReady,
    input  pcWrite, pcWriteCond, isbeq, iorD, memRead, memWrite, irWrite,
           regDst, memtoReg, regWrite, aluSrcA, aluSrcB, aluOp, pcSource,
           illegal, state
  );
endinterface
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_fsm
// Description : Multicycle MIPS control sequencer with memory-ready stalls.
// Revision    : 1.0
// ============================================================================
module mc_control_fsm (
  input  wire logic          clk,
  input  wire logic          rst,
  mc_control_fsm_if.master   bus
);
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_RTEX   = 4'd7;
  localparam logic [3:0] S_RTWB   = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;
  localparam logic [3:0] S_IMMEX  = 4'd11;
  localparam logic [3:0] S_IMMWB  = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [3:0] rt_alu;
  logic       rt_ok;
  logic       op_ok;
  logic       legal;
  logic       is_slt;
  logic       is_slti;
  wire        unused_zero = bus.zero;

  always_comb begin
    rt_alu = ALU_ADD;
    rt_ok  = 1'b1;
    case (bus.funct)
      FN_ADD:  rt_alu = ALU_ADD;
      FN_SUB:  rt_alu = ALU_SUB;
      FN_AND:  rt_alu = ALU_AND;
      FN_OR:   rt_alu = ALU_OR;
      FN_NOR:  rt_alu = ALU_NOR;
      FN_SLT:  rt_alu = ALU_SLT;
      default: rt_ok  = 1'b0;
    endcase
  end

  always_comb begin
    case (bus.opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_SLTI: op_ok = 1'b1;
      default: op_ok = 1'b0;
    endcase
  end

  assign legal   = op_ok && ((bus.opcode != OP_RTYPE) || rt_ok);
  assign is_slt  = (bus.funct == FN_SLT);
  assign is_slti = (bus.opcode == OP_SLTI);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = bus.memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (!legal) state_d = S_FETCH;
        else begin
          case (bus.opcode)
            OP_LW, OP_SW:     state_d = S_MEMADR;
            OP_RTYPE:         state_d = S_RTEX;
            OP_BEQ, OP_BNE:   state_d = S_BRANCH;
            OP_J:             state_d = S_JUMP;
            default:          state_d = S_IMMEX;
          endcase
        end
      end
      S_MEMADR: state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = bus.memReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = bus.memReady ? S_FETCH : S_MEMWR;
      S_RTEX:   state_d = S_RTWB;
      S_RTWB:   state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_IMMEX:  state_d = S_IMMWB;
      S_IMMWB:  state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  // Write-back states reuse the execute-state ALU selects so the lt flag stays valid.
  always_comb begin
    bus.pcWrite     = 1'b0;
    bus.pcWriteCond = 1'b0;
    bus.isbeq       = 1'b0;
    bus.iorD        = 1'b0;
    bus.memRead     = 1'b0;
    bus.memWrite    = 1'b0;
    bus.irWrite     = 1'b0;
    bus.regDst      = 1'b0;
    bus.memtoReg    = 2'b00;
    bus.regWrite    = 1'b0;
    bus.aluSrcA     = 1'b0;
    bus.aluSrcB     = 2'b00;
    bus.aluOp       = ALU_AND;
    bus.pcSource    = 2'b00;
    bus.illegal     = 1'b0;
    bus.state       = state_q;
    case (state_q)
      S_FETCH: begin
        bus.memRead = 1'b1;
        bus.aluSrcB = 2'b01;
        bus.aluOp   = ALU_ADD;
        bus.irWrite = bus.memReady;
        bus.pcWrite = bus.memReady;
      end
      S_DECODE: begin
        bus.aluSrcB = 2'b10;
        bus.aluOp   = ALU_ADD;
        bus.illegal = !legal;
      end
      S_MEMADR: begin
        bus.aluSrcA = 1'b1;
        bus.aluSrcB = 2'b10;
        bus.aluOp   = ALU_ADD;
      end
      S_MEMRD: begin
        bus.memRead = 1'b1;
        bus.iorD    = 1'b1;
      end
      S_MEMWB: begin
        bus.regWrite = 1'b1;
        bus.memtoReg = 2'b10;
      end
      S_MEMWR: begin
        bus.memWrite = 1'b1;
        bus.iorD     = 1'b1;
      end
      S_RTEX, S_RTWB: begin
        bus.aluSrcA = 1'b1;
        bus.aluOp   = rt_alu;
        if (state_q == S_RTWB) begin
          bus.regWrite = 1'b1;
          bus.regDst   = 1'b1;
          bus.memtoReg = {1'b0, is_slt};
        end
      end
      S_BRANCH: begin
        bus.aluSrcA     = 1'b1;
        bus.aluOp       = ALU_SUB;
        bus.pcWriteCond = 1'b1;
        bus.pcSource    = 2'b01;
        bus.isbeq       = (bus.opcode == OP_BEQ);
      end
      S_JUMP: begin
        bus.pcWrite  = 1'b1;
        bus.pcSource = 2'b10;
      end
      S_IMMEX, S_IMMWB: begin
        bus.aluSrcA = 1'b1;
        bus.aluSrcB = 2'b10;
        bus.aluOp   = is_slti ? ALU_SLT : ALU_ADD;
        if (state_q == S_IMMWB) begin
          bus.regWrite = 1'b1;
          bus.memtoReg = {1'b0, is_slti};
        end
      end
      default: ;
    endcase
  end
endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_control_fsm
// Description : Trace-model bench for the multicycle control sequencer.
// Revision    : 1.0
// ============================================================================
module tb_mc_control_fsm;
  typedef struct packed {
    logic       pcWrite, pcWriteCond, isbeq, iorD, memRead, memWrite, irWrite, regDst;
    logic [1:0] memtoReg;
    logic       regWrite, aluSrcA;
    logic [1:0] aluSrcB;
    logic [3:0] aluOp;
    logic [1:0] pcSource;
    logic       illegal;
    logic [3:0] state;
  } outs_t;

  typedef struct {
    logic       mr;
    logic       z;
    logic [5:0] op;
    logic [5:0] fn;
    outs_t      exp;
    int         tag;
  } step_t;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, JMP = 6'b000010, ADDI = 6'b001000, SLTI = 6'b001010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  step_t plan[$];

  mc_control_fsm_if bus ();
  mc_control_fsm dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == RT) return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
    return op inside {LW, SW, BEQ, BNE, JMP, ADDI, SLTI};
  endfunction

  function automatic logic [3:0] rt_op(input logic [5:0] fn);
    case (fn)
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b100111: return 4'b1100;
      6'b101010: return 4'b0111;
      default:   return 4'b0010;
    endcase
  endfunction

  // Expected controls for one step of an instruction, straight from the state table.
  function automatic outs_t exp_step(input int st, input logic [5:0] op, input logic [5:0] fn, input logic mr);
    outs_t o = '0;
    o.state = 4'(st);
    case (st)
      1: begin o.memRead = 1; o.aluSrcB = 2'b01; o.aluOp = 4'b0010; o.irWrite = mr; o.pcWrite = mr; end
      2: begin o.aluSrcB = 2'b10; o.aluOp = 4'b0010; o.illegal = !legal(op, fn); end
      3: begin o.aluSrcA = 1; o.aluSrcB = 2'b10; o.aluOp = 4'b0010; end
      4: begin o.memRead = 1; o.iorD = 1; end
      5: begin o.regWrite = 1; o.memtoReg = 2'b10; end
      6: begin o.memWrite = 1; o.iorD = 1; end
      7, 8: begin
        o.aluSrcA = 1; o.aluOp = rt_op(fn);
        if (st == 8) begin o.regWrite = 1; o.regDst = 1; o.memtoReg = (fn == 6'b101010) ? 2'b01 : 2'b00; end
      end
      9: begin o.aluSrcA = 1; o.aluOp = 4'b0110; o.pcWriteCond = 1; o.pcSource = 2'b01; o.isbeq = (op == BEQ); end
      10: begin o.pcWrite = 1; o.pcSource = 2'b10; end
      11, 12: begin
        o.aluSrcA = 1; o.aluSrcB = 2'b10; o.aluOp = (op == SLTI) ? 4'b0111 : 4'b0010;
        if (st == 12) begin o.regWrite = 1; o.memtoReg = (op == SLTI) ? 2'b01 : 2'b00; end
      end
      default: ;
    endcase
    return o;
  endfunction

  task automatic push(input int st, input logic [5:0] op, input logic [5:0] fn, input logic mr);
    step_t e;
    e.mr = mr; e.z = 1'($urandom_range(0, 1)); e.op = op; e.fn = fn;
    e.exp = exp_step(st, op, fn, mr);
    e.tag = 0;
    if (st == 8 && fn == 6'b100000) e.tag = 1;
    if (st == 9) e.tag = (op == BNE) ? 2 : 3;
    if (st == 11 && op == SLTI) e.tag = 4;
    if (st == 12 && op == SLTI) e.tag = 5;
    if (st == 5) e.tag = 6;
    if (st == 2 && !legal(op, fn)) e.tag = 7;
    if (st == 4 && !mr) e.tag = 8;
    plan.push_back(e);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // fw/mw: cycles memReady stays low in FETCH / the memory state; fin=0 leaves the access pending.
  task automatic add_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw, input bit fin);
    for (int i = 0; i < fw; i++) push(1, op, fn, 1'b0);
    push(1, op, fn, 1'b1);
    push(2, op, fn, rb());
    if (!legal(op, fn)) return;
    case (op)
      LW: begin
        push(3, op, fn, rb());
        for (int i = 0; i < mw; i++) push(4, op, fn, 1'b0);
        if (!fin) return;
        push(4, op, fn, 1'b1);
        push(5, op, fn, rb());
      end
      SW: begin
        push(3, op, fn, rb());
        for (int i = 0; i < mw; i++) push(6, op, fn, 1'b0);
        push(6, op, fn, 1'b1);
      end
      RT: begin push(7, op, fn, rb()); push(8, op, fn, rb()); end
      BEQ, BNE: push(9, op, fn, rb());
      JMP: push(10, op, fn, rb());
      default: begin push(11, op, fn, rb()); push(12, op, fn, rb()); end
    endcase
  endtask

  function automatic outs_t get_act();
    outs_t a;
    a.pcWrite = bus.pcWrite; a.pcWriteCond = bus.pcWriteCond; a.isbeq = bus.isbeq;
    a.iorD = bus.iorD; a.memRead = bus.memRead; a.memWrite = bus.memWrite;
    a.irWrite = bus.irWrite; a.regDst = bus.regDst; a.memtoReg = bus.memtoReg;
    a.regWrite = bus.regWrite; a.aluSrcA = bus.aluSrcA; a.aluSrcB = bus.aluSrcB;
    a.aluOp = bus.aluOp; a.pcSource = bus.pcSource; a.illegal = bus.illegal; a.state = bus.state;
    return a;
  endfunction

  task automatic lit(input string name, input logic [7:0] got, input logic [7:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // Drive one planned cycle per falling edge and compare the DUT with the model.
  always @(negedge clk) begin : drive_cmp
    step_t e;
    outs_t a;
    if (plan.size() > 0) begin
      e = plan.pop_front();
      bus.opcode = e.op; bus.funct = e.fn; bus.memReady = e.mr; bus.zero = e.z;
      #1;
      a = get_act();
      tests++;
      if (a !== e.exp) begin
        fails++;
        $display("FAIL trace op=%b fn=%b got %h want %h at %0t", e.op, e.fn, a, e.exp, $time);
      end
      lit("exclusive_strobes", {6'd0, a.pcWrite & a.pcWriteCond, a.regWrite & a.memWrite}, 8'd0);
      case (e.tag)
        1: lit("add_rtwb", {4'd0, a.regWrite, a.regDst, a.memtoReg}, 8'b0000_1100);
        2: lit("bne_branch", {a.pcWriteCond, a.isbeq, a.pcSource, a.aluOp}, 8'b1001_0110);
        3: lit("beq_branch", {a.pcWriteCond, a.isbeq, a.pcSource, a.aluOp}, 8'b1101_0110);
        4: lit("slti_immex", {4'd0, a.aluOp}, 8'b0000_0111);
        5: lit("slti_immwb", {4'd0, a.regWrite, a.regDst, a.memtoReg}, 8'b0000_1001);
        6: lit("lw_memwb", {5'd0, a.regWrite, a.memtoReg}, 8'b0000_0110);
        7: lit("illegal_decode", {3'd0, a.illegal, a.state}, 8'b0001_0010);
        8: lit("memrd_hold", {2'd0, a.iorD, a.memRead, a.state}, 8'b0011_0100);
        default: ;
      endcase
    end
  end

  task automatic wait_empty();
    for (int i = 0; i < 2000 && plan.size() > 0; i++) @(posedge clk);
    if (plan.size() > 0) begin
      tests++; fails++;
      $display("FAIL timeout plan_left=%0d want 0", plan.size());
      plan.delete();
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    push(0, RT, 6'b0, rb());
  endtask

  initial begin
    #1;
    lit("reset_state", {4'd0, bus.state}, 8'd0);
    tests++;
    if (get_act() !== '0) begin fails++; $display("FAIL reset_outs got %h want 0", get_act()); end
    repeat (2) @(posedge clk);
    release_reset();
    add_instr(RT,   6'b100000, 0, 0, 1);
    add_instr(LW,   6'b000000, 0, 3, 1);
    add_instr(SW,   6'b011111, 2, 1, 1);
    add_instr(BNE,  6'b000000, 0, 0, 1);
    add_instr(BEQ,  6'b000000, 1, 0, 1);
    add_instr(JMP,  6'b101010, 0, 0, 1);
    add_instr(ADDI, 6'b000000, 0, 0, 1);
    add_instr(SLTI, 6'b000000, 0, 0, 1);
    add_instr(RT,   6'b100010, 0, 0, 1);
    add_instr(RT,   6'b100100, 0, 0, 1);
    add_instr(RT,   6'b100101, 0, 0, 1);
    add_instr(RT,   6'b100111, 0, 0, 1);
    add_instr(RT,   6'b101010, 0, 0, 1);
    add_instr(6'b111111, 6'b100000, 0, 0, 1);
    add_instr(RT,   6'b000000, 0, 0, 1);
    add_instr(LW,   6'b000000, 0, 2, 0);
    wait_empty();
    lit("pre_abort_memrd", {3'd0, bus.memRead, bus.state}, 8'b0001_0100);
    #3 rst = 1'b1;
    #1;
    lit("abort_state", {4'd0, bus.state}, 8'd0);
    tests++;
    if (get_act() !== '0) begin fails++; $display("FAIL abort_outs got %h want 0", get_act()); end
    repeat (2) @(posedge clk);
    #1;
    lit("held_reset", {3'd0, bus.memRead, bus.state}, 8'd0);
    release_reset();
    add_instr(RT,   6'b101010, 1, 0, 1);
    add_instr(SW,   6'b000000, 0, 0, 1);
    add_instr(6'b111111, 6'b000000, 0, 0, 1);
    add_instr(LW,   6'b000000, 0, 0, 1);
    wait_empty();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
